// File: rtl/wisc_pkg.sv
// wisc_pkg: shared opcode/condition-code enums and flag bit positions
package wisc_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR, OP_PADDSB,
    OP_LW, OP_SW, OP_LHB, OP_LLB, OP_B, OP_BR, OP_PCS, OP_HLT
  } opcode_t;
  typedef enum logic [2:0] {
    CC_NE, CC_EQ, CC_GT, CC_LT, CC_GE, CC_LE, CC_OV, CC_UN
  } ccc_t;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;
  function automatic logic sets_zvn(opcode_t op);
    return op == OP_ADD || op == OP_SUB;
  endfunction
  function automatic logic sets_z(opcode_t op);
    return sets_zvn(op) || op == OP_XOR || op == OP_SLL || op == OP_SRA || op == OP_ROR;
  endfunction
endpackage

// File: rtl/ex_flag_stage_if.sv
// ex_flag_stage_if: EX-stage inputs, stage control, branch query and EX/MEM outputs
interface ex_flag_stage_if #(parameter int DW = 16);
  logic          ex_valid_i;
  logic [3:0]    ex_opcode_i;
  logic [DW-1:0] ex_sum_i;
  logic          ex_ovfl_i;
  logic [3:0]    ex_dst_i;
  logic          ex_wr_en_i;
  logic          stall_i;
  logic          flush_i;
  logic [2:0]    br_cond_i;
  logic          cond_met_o;
  logic [2:0]    flags_o;
  logic          mem_valid_o;
  logic [DW-1:0] mem_result_o;
  logic [3:0]    mem_opcode_o;
  logic [3:0]    mem_dst_o;
  logic          mem_wr_en_o;
  modport master (
    output ex_valid_i, ex_opcode_i, ex_sum_i, ex_ovfl_i, ex_dst_i, ex_wr_en_i, stall_i, flush_i, br_cond_i,
    input  cond_met_o, flags_o, mem_valid_o, mem_result_o, mem_opcode_o, mem_dst_o, mem_wr_en_o
  );
  modport slave (
    input  ex_valid_i, ex_opcode_i, ex_sum_i, ex_ovfl_i, ex_dst_i, ex_wr_en_i, stall_i, flush_i, br_cond_i,
    output cond_met_o, flags_o, mem_valid_o, mem_result_o, mem_opcode_o, mem_dst_o, mem_wr_en_o
  );
endinterface

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: evaluates a 3-bit condition code against {Z,V,N}
module branch_cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] ccc,
  output logic       met
);
  logic z, v, n;
  logic [7:0] tbl;
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];
  // indexed by ccc: UN, OV, LE, GE, LT, GT, EQ, NE
  assign tbl = {1'b1, v, n | z, z | ~n, n, ~z & ~n, z, ~z};
  assign met = tbl[ccc];
endmodule

// File: rtl/ex_flag_stage.sv
// ex_flag_stage: flag register update, branch condition evaluation and EX/MEM pipeline register
module ex_flag_stage
  import wisc_pkg::*;
#(
  parameter bit FLAG_BYPASS = 1'b1,
  parameter int DW = 16
) (
  input logic            clk,
  input logic            rst_n,
  ex_flag_stage_if.slave bus
);
  logic [DW-1:0] sum;
  logic [2:0]    flags, flags_nxt;
  logic          advance, upd_z, upd_vn;
  opcode_t       op;
  logic          mem_valid, mem_wr_en;
  logic [DW-1:0] mem_result;
  logic [3:0]    mem_opcode, mem_dst;
  assign sum     = bus.ex_sum_i;
  assign op      = opcode_t'(bus.ex_opcode_i);
  assign advance = bus.ex_valid_i & ~bus.stall_i & ~bus.flush_i;
  assign upd_z   = advance & sets_z(op);
  assign upd_vn  = advance & sets_zvn(op);
  always_comb begin
    flags_nxt         = flags;
    flags_nxt[FLAG_Z] = upd_z ? (sum == '0) : flags[FLAG_Z];
    flags_nxt[FLAG_V] = upd_vn ? bus.ex_ovfl_i : flags[FLAG_V];
    flags_nxt[FLAG_N] = upd_vn ? sum[DW-1] : flags[FLAG_N];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flags <= 3'b000;
    else flags <= flags_nxt;
  // a flush overrides a stall and drops a bubble into MEM; payload is held on bubbles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_valid  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_result <= '0;
      mem_opcode <= '0;
      mem_dst    <= '0;
    end else if (bus.flush_i || !bus.stall_i) begin
      mem_valid <= advance;
      mem_wr_en <= advance & bus.ex_wr_en_i;
      if (advance) begin
        mem_result <= sum;
        mem_opcode <= bus.ex_opcode_i;
        mem_dst    <= bus.ex_dst_i;
      end
    end
  branch_cond_eval u_cond (
    .flags(FLAG_BYPASS ? flags_nxt : flags),
    .ccc  (bus.br_cond_i),
    .met  (bus.cond_met_o)
  );
  assign bus.flags_o      = flags;
  assign bus.mem_valid_o  = mem_valid;
  assign bus.mem_wr_en_o  = mem_wr_en;
  assign bus.mem_result_o = mem_result;
  assign bus.mem_opcode_o = mem_opcode;
  assign bus.mem_dst_o    = mem_dst;
endmodule

// File: tb/tb_ex_flag_stage.sv
// tb_ex_flag_stage: directed table-driven bench for ex_flag_stage with bypass and non-bypass instances
module tb_ex_flag_stage;
  import wisc_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ex_flag_stage_if b1 ();
  ex_flag_stage_if b0 ();
  ex_flag_stage #(.FLAG_BYPASS(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  ex_flag_stage #(.FLAG_BYPASS(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  logic [2:0] sf, sc;
  logic sm;
  branch_cond_eval u_bce (.flags(sf), .ccc(sc), .met(sm));
  int errs = 0;
  int checks = 0;
  typedef struct packed {
    logic v; logic [3:0] op; logic [15:0] sum; logic ov; logic [3:0] dst; logic wr;
    logic st; logic fl; logic [2:0] cc;
    logic e_c1; logic e_c0; logic [2:0] e_flags; logic e_valid; logic [15:0] e_res; logic e_wr;
  } vec_t;
  vec_t tv [12];
  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(logic v, logic [3:0] op, logic [15:0] s, logic ov, logic [3:0] d, logic w,
                       logic st, logic fl, logic [2:0] cc);
    b1.ex_valid_i = v; b1.ex_opcode_i = op; b1.ex_sum_i = s; b1.ex_ovfl_i = ov; b1.ex_dst_i = d;
    b1.ex_wr_en_i = w; b1.stall_i = st; b1.flush_i = fl; b1.br_cond_i = cc;
    b0.ex_valid_i = v; b0.ex_opcode_i = op; b0.ex_sum_i = s; b0.ex_ovfl_i = ov; b0.ex_dst_i = d;
    b0.ex_wr_en_i = w; b0.stall_i = st; b0.flush_i = fl; b0.br_cond_i = cc;
  endtask
  task automatic chk_mem(string nm, logic [2:0] fl, logic v, logic [15:0] r, logic w);
    chk({nm, " flags"}, {13'd0, b1.flags_o}, {13'd0, fl});
    chk({nm, " valid"}, {15'd0, b1.mem_valid_o}, {15'd0, v});
    chk({nm, " result"}, b1.mem_result_o, r);
    chk({nm, " wr_en"}, {15'd0, b1.mem_wr_en_o}, {15'd0, w});
  endtask
  function automatic logic ref_met(logic [2:0] f, logic [2:0] c);
    logic z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction
  initial begin
    //       v  op         sum       ov dst  wr st fl cc    c1 c0 flags   vl res       wr
    tv[0]  = '{1'b1, OP_ADD,    16'h0000, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 3'b100, 1'b1, 16'h0000, 1'b1};
    tv[1]  = '{1'b1, OP_SUB,    16'h8000, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0, 3'b011, 1'b1, 16'h8000, 1'b1};
    tv[2]  = '{1'b1, OP_XOR,    16'h0001, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 3'b011, 1'b1, 16'h0001, 1'b1};
    tv[3]  = '{1'b1, OP_PADDSB, 16'h0000, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 3'b011, 1'b1, 16'h0000, 1'b1};
    tv[4]  = '{1'b1, OP_ADD,    16'h7FFF, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 3'b010, 1'b1, 16'h7FFF, 1'b0};
    tv[5]  = '{1'b0, OP_ADD,    16'h0000, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'b010, 1'b0, 16'h7FFF, 1'b0};
    tv[6]  = '{1'b1, OP_ADD,    16'h0000, 1'b0, 4'd6, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 3'b010, 1'b0, 16'h7FFF, 1'b0};
    tv[7]  = '{1'b1, OP_SLL,    16'h0000, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 3'b110, 1'b1, 16'h0000, 1'b1};
    tv[8]  = '{1'b1, OP_SRA,    16'hFFFF, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 3'b010, 1'b1, 16'hFFFF, 1'b1};
    tv[9]  = '{1'b1, OP_ROR,    16'h0000, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 3'b110, 1'b1, 16'h0000, 1'b1};
    tv[10] = '{1'b1, OP_SUB,    16'h0005, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'b000, 1'b1, 16'h0005, 1'b1};
    tv[11] = '{1'b1, OP_LW,     16'h0000, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 3'd7, 1'b1, 1'b1, 3'b000, 1'b1, 16'h0000, 1'b1};
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    #1;
    chk_mem("reset", 3'b000, 1'b0, 16'h0000, 1'b0);
    chk("reset opcode", {12'd0, b1.mem_opcode_o}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tv[i].v, tv[i].op, tv[i].sum, tv[i].ov, tv[i].dst, tv[i].wr, tv[i].st, tv[i].fl, tv[i].cc);
      #1;
      chk($sformatf("vec%0d cond_bypass", i), {15'd0, b1.cond_met_o}, {15'd0, tv[i].e_c1});
      chk($sformatf("vec%0d cond_nobypass", i), {15'd0, b0.cond_met_o}, {15'd0, tv[i].e_c0});
      @(posedge clk);
      #1;
      chk_mem($sformatf("vec%0d", i), tv[i].e_flags, tv[i].e_valid, tv[i].e_res, tv[i].e_wr);
      if (tv[i].e_valid) chk($sformatf("vec%0d dst", i), {12'd0, b1.mem_dst_o}, {12'd0, tv[i].dst});
    end
    // stall sequence: SUB 0x8000 ovfl0 sets N, then ADD 0 held for 3 stalled cycles
    @(negedge clk);
    drive(1'b1, OP_SUB, 16'h8000, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 3'd1);
    @(posedge clk);
    #1;
    chk_mem("pre-stall", 3'b001, 1'b1, 16'h8000, 1'b1);
    @(negedge clk);
    drive(1'b1, OP_ADD, 16'h0000, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 3'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d cond_bypass", i), {15'd0, b1.cond_met_o}, 16'h0);
      @(posedge clk);
      #1;
      chk_mem($sformatf("stall%0d", i), 3'b001, 1'b1, 16'h8000, 1'b1);
      chk($sformatf("stall%0d dst", i), {12'd0, b1.mem_dst_o}, 16'd3);
      @(negedge clk);
    end
    drive(1'b1, OP_ADD, 16'h0000, 1'b0, 4'd4, 1'b1, 1'b1, 1'b1, 3'd1);
    @(posedge clk);
    #1;
    chk_mem("stall+flush", 3'b001, 1'b0, 16'h8000, 1'b0);
    // async reset mid-stream
    @(negedge clk);
    drive(1'b1, OP_ADD, 16'h0000, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 3'd1);
    @(posedge clk);
    #1;
    chk_mem("pre-reset", 3'b100, 1'b1, 16'h0000, 1'b1);
    drive(1'b1, OP_SUB, 16'h1234, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_mem("async reset", 3'b000, 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    chk_mem("held reset", 3'b000, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    // condition evaluator sweep
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 8; c++) begin
        sf = 3'(f);
        sc = 3'(c);
        #1;
        chk($sformatf("cond f=%0d c=%0d", f, c), {15'd0, sm}, {15'd0, ref_met(sf, sc)});
      end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
